// File: rtl/lcd_timing_pkg.sv
// Shared constants, state type and helpers for the 480x272 RGB565 LCD timing sequencer.
package lcd_timing_pkg;

  localparam int CNT_W = 10;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 43;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lcd_timing_counter.sv
// Pixel-tick qualified horizontal/vertical position counters with region decode.
module lcd_timing_counter
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             frame_last
);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Region order on both axes is active, front porch, sync, back porch.
  assign active     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_act  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vsync_act  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD timing sequencer: counters (s0), pixel request stage (s1), registered panel outputs (s2).
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             enable,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  input  logic             pix_valid,
  input  logic [R_W-1:0]   pix_r,
  input  logic [G_W-1:0]   pix_g,
  input  logic [B_W-1:0]   pix_b,
  output logic             lcd_de,
  output logic             lcd_hsync,
  output logic             lcd_vsync,
  output logic [R_W-1:0]   lcd_r,
  output logic [G_W-1:0]   lcd_g,
  output logic [B_W-1:0]   lcd_b,
  output logic             frame_start,
  output logic             line_start,
  output logic             underflow,
  input  logic             underflow_clr
);

  state_t           state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hsync_act;
  logic             vsync_act;
  logic             frame_last;
  logic             go;
  logic             advance;
  logic             de_d1;
  logic             hs_d1;
  logic             vs_d1;
  logic             fs_q;
  logic             ls_q;
  logic             miss;

  // In IDLE the counters sit at 0, so an enable tick processes (0,0) immediately.
  assign go      = (state != IDLE) || enable;
  assign advance = pix_ce && go;

  lcd_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pix_req <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
      de_d1   <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (pix_ce) begin
      pix_req <= go && active;
      de_d1   <= go && active;
      hs_d1   <= go && hsync_act;
      vs_d1   <= go && vsync_act;
      fs_q    <= go && active && (h_cnt == '0) && (v_cnt == '0);
      ls_q    <= go && active && (h_cnt == '0);
      if (go && active) begin
        pix_x <= h_cnt;
        pix_y <= v_cnt;
      end
      // A frame always runs to completion; enable is only honoured at the final wrap.
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN: begin
          if (!enable) state <= frame_last ? IDLE : DRAIN;
        end
        DRAIN:   if (frame_last) state <= enable ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign miss = pix_ce && pix_req && !pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_de    <= 1'b0;
      lcd_hsync <= ~HS_POL;
      lcd_vsync <= ~VS_POL;
      lcd_r     <= '0;
      lcd_g     <= '0;
      lcd_b     <= '0;
    end else if (pix_ce) begin
      lcd_de    <= de_d1;
      lcd_hsync <= hs_d1 ? HS_POL : ~HS_POL;
      lcd_vsync <= vs_d1 ? VS_POL : ~VS_POL;
      if (pix_req && pix_valid) begin
        lcd_r <= pix_r;
        lcd_g <= pix_g;
        lcd_b <= pix_b;
      end else begin
        lcd_r <= '0;
        lcd_g <= '0;
        lcd_b <= '0;
      end
    end
  end

  // Set wins over clear so a miss is never lost to a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (miss) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  assign frame_start = fs_q && pix_ce;
  assign line_start  = ls_q && pix_ce;

endmodule
